rstatus_exc_ctrl: RTL

// - Consumer end of the $rstatus/write_30 interface: captures overflow-status writes from the execute stage.
// - Holds the architectural $r30 copy and queues pending exceptions (code + faulting PC).
// - Presents each queued exception to the handler with a valid/ack handshake; answers bex/setx.

---
 rtl/exc_pkg.sv | 34 +++
 rtl/exc_fifo.sv | 82 ++++++++
 rtl/rstatus_exc_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the $rstatus exception controller:
//   - overflow status codes written by the execute stage
//   - controller FSM state encoding
//   - pending-exception queue entry layout (2-bit code + 32-bit PC = 34 bits)
//   - helper that decides whether a status write carries a real exception
// ---------------------------------------------------------------------------
package exc_pkg;

  localparam logic [1:0] EXC_ADD  = 2'd1;
  localparam logic [1:0] EXC_ADDI = 2'd2;
  localparam logic [1:0] EXC_SUB  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SIGNAL  = 2'd1,
    ST_SERVICE = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] pc;
  } exc_entry_t;

  localparam int ENTRY_W = $bits(exc_entry_t);

  // Only codes 1..3 are real exceptions; anything else on the status bus
  // is treated as noise from the producer and ignored.
  function automatic logic is_valid_code(input logic [31:0] code);
    return (code != 32'd0) && (code < 32'd4);
  endfunction

endpackage

// File: rtl/exc_fifo.sv
// ---------------------------------------------------------------------------
// exc_fifo
// DEPTH x WIDTH synchronous FIFO holding pending exceptions.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is silently ignored (the parent tracks the loss).
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous, active-low
//   push   in   write wdata at the tail
//   pop    in   retire the head entry (ignored when empty)
//   wdata  in   WIDTH  entry to append
//   rdata  out  WIDTH  current head entry
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  clog2(DEPTH)+1 occupancy
// ---------------------------------------------------------------------------
module exc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int QCNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [QCNT_W-1:0] count
);

  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [QCNT_W-1:0] CNT_ONE = QCNT_W'(1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [QCNT_W-1:0] r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign full  = (r_count == QCNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rdPtr];

  // A pop frees the head slot this cycle, so a push into a full FIFO can
  // land in the slot being vacated without overwriting live data.
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  // Storage carries no reset: contents are meaningless while empty.
  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rstatus_exc_ctrl.sv
// ---------------------------------------------------------------------------
// rstatus_exc_ctrl
// Consumer end of the $rstatus/write_30 interface. Holds the architectural
// $r30 copy, queues overflow exceptions (code + faulting PC) and presents
// them one at a time to the handler through a valid/ack/eret handshake.
// Optional feature macro: RSTATUS_EXC_COUNT_EN adds per-code saturating
// exception counters (cnt_add, cnt_addi, cnt_sub).
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low
//   write_30     in   status write strobe from execute
//   rstatus_in   in   32  status code (1 add, 2 addi, 3 sub)
//   pc_in        in   32  PC of the faulting instruction
//   setx_we      in   setx writes $r30
//   setx_val     in   27  setx immediate (zero-extended)
//   bex_query    in   bex in execute this cycle
//   handler_ack  in   handler accepts the presented exception
//   eret         in   handler done, retire head entry
//   rstatus_q    out  32  current $r30
//   bex_taken    out  bex_query && $r30 != 0
//   exc_valid    out  head exception presented
//   exc_code     out  2   head code
//   exc_pc       out  32  head PC (EPC)
//   q_full       out  queue full
//   lost         out  sticky: an exception was dropped
//   cnt_add/cnt_addi/cnt_sub  out  CNT_W  (RSTATUS_EXC_COUNT_EN only)
// ---------------------------------------------------------------------------
module rstatus_exc_ctrl
  import exc_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef RSTATUS_EXC_COUNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_30,
  input  logic [31:0] rstatus_in,
  input  logic [31:0] pc_in,
  input  logic        setx_we,
  input  logic [26:0] setx_val,
  input  logic        bex_query,
  input  logic        handler_ack,
  input  logic        eret,
  output logic [31:0] rstatus_q,
  output logic        bex_taken,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        q_full,
`ifdef RSTATUS_EXC_COUNT_EN
  output logic [CNT_W-1:0] cnt_add,
  output logic [CNT_W-1:0] cnt_addi,
  output logic [CNT_W-1:0] cnt_sub,
`endif
  output logic        lost
);

  localparam int QCNT_W = $clog2(DEPTH) + 1;
  localparam logic [QCNT_W-1:0] CNT_ONE = QCNT_W'(1);

  exc_state_e        r_state;
  exc_state_e        w_stateNext;
  logic [31:0]       r_rstatus;
  logic              r_lost;
  logic              w_validWrite;
  logic              w_pop;
  logic              w_pushAccepted;
  logic              w_remain;
  logic              w_full;
  logic              w_empty;
  logic [QCNT_W-1:0] w_count;
  exc_entry_t        w_pushEntry;
  exc_entry_t        w_headEntry;

  assign w_validWrite = write_30 && is_valid_code(rstatus_in);
  assign w_pop        = (r_state == ST_SERVICE) && eret;
  assign w_pushEntry  = '{code: rstatus_in[1:0], pc: pc_in};

  // Mirrors the FIFO's acceptance rule so the FSM and loss flag agree with it.
  assign w_pushAccepted = w_validWrite && (!w_full || w_pop);

  // Entries left after this cycle's pop, counting a same-cycle push.
  assign w_remain = (w_count > CNT_ONE) || w_pushAccepted;

  exc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_validWrite),
    .pop   (w_pop),
    .wdata (w_pushEntry),
    .rdata (w_headEntry),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // $r30: an exception write always beats a same-cycle setx.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstatus <= '0;
    end else if (w_validWrite) begin
      r_rstatus <= rstatus_in;
    end else if (setx_we) begin
      r_rstatus <= {5'b0, setx_val};
    end
  end

  // Loss flag stays set until reset so software can detect dropped faults.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lost <= 1'b0;
    end else if (w_validWrite && !w_pushAccepted) begin
      r_lost <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Handshake: ack is only meaningful in SIGNAL, eret only in SERVICE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_stateNext = ST_SIGNAL;
        end
      end
      ST_SIGNAL: begin
        if (handler_ack) begin
          w_stateNext = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          w_stateNext = w_remain ? ST_SIGNAL : ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign rstatus_q = r_rstatus;
  assign bex_taken = bex_query && (r_rstatus != 32'd0);
  assign exc_valid = (r_state == ST_SIGNAL);
  assign exc_code  = w_empty ? 2'd0 : w_headEntry.code;
  assign exc_pc    = w_empty ? 32'd0 : w_headEntry.pc;
  assign q_full    = w_full;
  assign lost      = r_lost;

`ifdef RSTATUS_EXC_COUNT_EN
  logic [CNT_W-1:0] r_cntAdd;
  logic [CNT_W-1:0] r_cntAddi;
  logic [CNT_W-1:0] r_cntSub;

  // Counters see every valid write, including ones the queue had to drop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cntAdd  <= '0;
      r_cntAddi <= '0;
      r_cntSub  <= '0;
    end else if (w_validWrite) begin
      if ((rstatus_in[1:0] == EXC_ADD) && (r_cntAdd != '1)) begin
        r_cntAdd <= r_cntAdd + CNT_W'(1);
      end
      if ((rstatus_in[1:0] == EXC_ADDI) && (r_cntAddi != '1)) begin
        r_cntAddi <= r_cntAddi + CNT_W'(1);
      end
      if ((rstatus_in[1:0] == EXC_SUB) && (r_cntSub != '1)) begin
        r_cntSub <= r_cntSub + CNT_W'(1);
      end
    end
  end

  assign cnt_add  = r_cntAdd;
  assign cnt_addi = r_cntAddi;
  assign cnt_sub  = r_cntSub;
`endif

endmodule
